// File: rtl/bus_ram_responder.sv
// bus_ram_responder: responder end of the single-word we/rd/ack memory bus.
// On-chip word RAM with a fixed, parameterized response latency.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   addr_i         byte address, word index = addr_i[ADDR_W+1:2]
//   data_i/data_o  write data / read data (held until the next read ack)
//   we_i, rd_i     request levels (both high = write)
//   ack_o          one-cycle completion pulse
//   busy_o         request in service (WAIT or ACK)
//   state_value    debug {state, err, 0, lat_cnt, req_cnt}
//   err_o          sticky protocol error (only with BUS_RESP_CHECK_EN)
//
// Optional macro BUS_RESP_CHECK_EN adds the err_o protocol checker.
module bus_ram_responder #(
  parameter int          ADDR_W   = 10,
  parameter int          LATENCY  = 4,
  parameter logic [31:0] INIT_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        we_i,
  input  logic        rd_i,
  output logic        ack_o,
  output logic        busy_o,
`ifdef BUS_RESP_CHECK_EN
  output logic        err_o,
`endif
  output logic [15:0] state_value
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [3:0]        lat_cnt, lat_nxt;
  logic [7:0]        req_cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       data_q;
  logic              wr_q;
  logic              commit;

  logic [31:0] mem [0:(1<<ADDR_W)-1] = '{default: INIT_VAL};

  logic              req;
  logic              cmt_we;
  logic [ADDR_W-1:0] cmt_idx;
  logic [31:0]       cmt_data;
  logic              unused_addr_bits;

  assign req              = we_i | rd_i;
  assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  // With LATENCY==1 the commit edge is the capture edge, so the live request
  // feeds the RAM; otherwise the latched copy does.
  assign cmt_we   = (state == IDLE) ? we_i                   : wr_q;
  assign cmt_idx  = (state == IDLE) ? addr_i[ADDR_W+1:2]     : idx_q;
  assign cmt_data = (state == IDLE) ? data_i                 : data_q;

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt = ACK;
            lat_nxt   = 4'd0;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            lat_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        lat_nxt = lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) begin
          state_nxt = ACK;
          commit    = 1'b1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
        lat_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        lat_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
      req_cnt <= 8'd0;
      data_o  <= 32'd0;
      idx_q   <= '0;
      data_q  <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      if (state == IDLE && req) begin
        idx_q  <= addr_i[ADDR_W+1:2];
        data_q <= data_i;
        wr_q   <= we_i;
      end
      if (state == ACK) req_cnt <= req_cnt + 8'd1;
      if (commit && !cmt_we) data_o <= mem[cmt_idx];
    end
  end

  // RAM has no reset; a write interrupted by rst never reaches it.
  always_ff @(posedge clk) begin
    if (!rst && commit && cmt_we) mem[cmt_idx] <= cmt_data;
  end

  assign ack_o  = (state == ACK);
  assign busy_o = (state != IDLE);

`ifdef BUS_RESP_CHECK_EN
  logic [31:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_o  <= 1'b0;
      addr_q <= 32'd0;
    end else begin
      if (state == IDLE && req) addr_q <= addr_i;
      if ((state == IDLE && we_i && rd_i) ||
          (state == WAIT && (!req || addr_i != addr_q)))
        err_o <= 1'b1;
    end
  end

  assign state_value = {state, err_o, 1'b0, lat_cnt, req_cnt};
`else
  assign state_value = {state, 2'b00, lat_cnt, req_cnt};
`endif

endmodule

// File: doc/bus_ram_responder.md
Name: bus_ram_responder

Overview:
- Target (responder) end of the single-word we/rd/ack memory bus that ddr3_dev exposes to bus initiators.
- On-chip word RAM with programmable response latency. Serves as a fast stand-in for ddr3_dev in bring-up and simulation, and as a scratchpad slave on the system bus.
- Runs on clk_sys. Exposes a 16-bit debug state word for the board LED mux.

Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2^ADDR_W 32-bit words.
- LATENCY, 4, cycles from first request-visible cycle to ack_o; legal range 1..15.
- INIT_VAL, 0, value of every RAM word at configuration (initial block only; not reset).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- addr_i  in  32  byte address; word index = addr_i[ADDR_W+1:2]; other bits ignored.
- data_i  in  32  write data.
- data_o  out  32  read data; valid in ack cycle of a read, held until next read ack.
- we_i  in  1  write request level.
- rd_i  in  1  read request level.
- ack_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high while a request is in service (WAIT or ACK state).
- state_value  out  16  debug: {state[1:0], 2'b0, lat_cnt[3:0], req_cnt[7:0]}.

Behaviour:
- Interface: clock clk; reset rst, synchronous, active-high.
- Protocol:
  - Initiator holds we_i or rd_i high, with addr_i/data_i stable, until it samples ack_o.
  - Initiator may present the next request in the cycle right after ack; no idle cycle is required.
- Request = (we_i | rd_i) seen in IDLE. we_i & rd_i both high: treated as a write.
- FSM states, encoding IDLE=0, WAIT=1, ACK=2:
  - IDLE: on request, latch addr/data/kind into internal regs. If LATENCY==1, go to ACK; else go to WAIT with lat_cnt=LATENCY-1.
  - WAIT: decrement lat_cnt each cycle. When lat_cnt==1, go to ACK.
  - ACK: ack_o=1 for exactly this cycle. Next state is IDLE. The request lines are re-evaluated in IDLE the following cycle, so a request held past ack is serviced again. This is the initiator's responsibility.
- Latency: request first visible in cycle c gives ack_o high in cycle c+LATENCY.
- Memory timing:
  - Write commits to RAM at the clock edge that enters ACK.
  - Read data is registered into data_o at that same edge.
  - Read-after-write to the same address in back-to-back requests returns the new data.
- Request capture:
  - The latched address/data are used, not live inputs.
  - Input changes during WAIT are ignored.
  - Dropping the request during WAIT does not abort it; ack still issues.
- Address wrap: bits above ADDR_W+1 are ignored, so address 4*2^ADDR_W aliases word 0. addr_i[1:0] is ignored.
- req_cnt: 8-bit, increments at each ACK, wraps 255→0.
- Outputs during reset: ack_o=0, busy_o=0, data_o=0, state=IDLE, lat_cnt=0, req_cnt=0.
- Reset mid-operation: any in-flight request is dropped with no ack, and an un-committed write is not performed. RAM contents are retained across reset.
- busy_o = (state != IDLE), registered.

Optional Feature:
- BUS_RESP_CHECK_EN defined: adds a sticky 1-bit output err_o (reset 0), set on any of:
  - we_i & rd_i both high in IDLE;
  - request level low during WAIT;
  - addr_i changed during WAIT.
- With BUS_RESP_CHECK_EN defined, state_value[13:12] = {err_o, 1'b0}; err_o clears only on rst.
- BUS_RESP_CHECK_EN undefined: no err_o port, no checker logic; state_value[13:12]=0.

Test Plan:
- LATENCY=4; write addr 0x10 data 0xDEADBEEF at cycle 0 → ack_o high only in cycle 4. Then read addr 0x10 → ack in cycle 9, data_o=0xDEADBEEF.
- LATENCY=1; initiator counter pattern (write N, then read N, repeated for N=1..300) → every read returns N; ack every other cycle at most; req_cnt wraps to 600 mod 256 = 88.
- ADDR_W=10; write 0x1234 at addr 0x1000 → read of addr 0x0000 returns 0x1234 (alias).
- Both we_i and rd_i high with data 0x55 at addr 0x20 → performs write; a later read of 0x20 returns 0x55; with BUS_RESP_CHECK_EN, err_o=1.
- Assert rst for 1 cycle during WAIT of a write of 0xAA to 0x40 → no ack_o; busy_o=0 next cycle; a later read of 0x40 returns the prior value (INIT_VAL).
- rd_i dropped and addr_i changed mid-WAIT → ack still issued at cycle c+LATENCY with data from the originally latched address.
